intersection_monitor: RTL and testbench
=======================================

# intersection_monitor

Synthesizable runtime safety monitor for the traffic-light intersection, generalised to `NUM_GROUPS` signal groups with a parametrised conflict matrix. It checks four properties on the green outputs of the intersection controller:
- no conflicting greens at the same time;
- minimum green duration;
- all-red clearance between conflicting groups;
- a saturating count of handovers for a selectable ordered pair.

It sits beside the controller in silicon and reports sticky error flags, replacing cover-only checking with live detection and event counting.

## Interface
Parameters:
- `NUM_GROUPS`, 4: number of signal groups. Index 0 = pedestrian, 1 = up, 2 = down, 3 = turn.
- `CONFLICT_MASK`, `16'h080E`: `NUM_GROUPS*NUM_GROUPS` bits. Bit `i*NUM_GROUPS+j` set means groups i and j conflict; either orientation counts. Default conflicting pairs: (0,1), (0,2), (0,3), (2,3).
- `MIN_GREEN`, 3: minimum consecutive green cycles per group, ≥1.
- `CLEAR_CYCLES`, 2: required all-red cycles between a group leaving green and a conflicting group entering green, ≥1.
- `CNT_W`, 8: width of the handover counter.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `green` in `NUM_GROUPS`: green indication per group, sampled every edge.
- `err_clr` in 1: synchronous clear of the sticky error flags.
- `sel_first` in `$clog2(NUM_GROUPS)`: group index giving up green in the handover being counted.
- `sel_second` in `$clog2(NUM_GROUPS)`: group index receiving green in that handover.
- `conflict_err` out 1: sticky; set when two conflicting groups are green together.
- `min_green_err` out 1: sticky; set when a green ended too early.
- `clear_err` out 1: sticky; set when a clearance interval was violated.
- `first_err_group` out `$clog2(NUM_GROUPS)`: lowest group index involved in the first error since the last clear.
- `handover_cnt` out `CNT_W`: saturating count of completed handovers for the selected pair.

## Operation
- `green_q` holds the previous sample of `green`.
  - Rise of group i: `green[i] & !green_q[i]`.
  - Fall of group i: `!green[i] & green_q[i]`.
- **Conflict check:** any conflicting pair (i,j) with `green[i] & green[j]` sets `conflict_err`. Offending group = min(i,j).
- **Minimum-green check:**
  - `grn_cnt[i]` = 0 while red; on each green cycle it increments, saturating at `MIN_GREEN`.
  - A fall while `grn_cnt[i] < MIN_GREEN` sets `min_green_err`. Offending group = i.
- **Clearance check:**
  - `red_cnt[i]` reloads to 0 on a fall of i.
  - While i is red, `red_cnt[i]` increments each cycle, saturating at `CLEAR_CYCLES`. The cycle of the fall counts as red cycle 1.
  - A rise of j while any conflicting i has `red_cnt[i] < CLEAR_CYCLES` sets `clear_err`. Offending group = min(i,j).
- **Handover FSM** (implements first && !second followed later by !first && second):
  - IDLE → ARMED when `green[sel_first] & !green[sel_second]`.
  - ARMED → IDLE, incrementing `handover_cnt` (saturating at all-ones), when `!green[sel_first] & green[sel_second]`.
  - ARMED is held otherwise.
  - If `sel_first == sel_second`, the FSM stays in IDLE.
  - Any change of `sel_first` or `sel_second` (relative to the previous cycle) forces IDLE with no count that cycle. The counter is not cleared.
- **Error capture:**
  - `first_err_group` is written only in a cycle where all three flags are currently 0 and at least one error fires.
  - If several errors fire together, the lowest offending index is captured.
- **Error clearing:**
  - `err_clr` zeroes all three flags and `first_err_group`.
  - A new error in the same cycle as `err_clr` wins: the flag is set and `first_err_group` is recaptured.
- `handover_cnt` is cleared only by `reset`.

## Timing
- Reset values:
  - Flags: 0.
  - `first_err_group`: 0.
  - `handover_cnt`: 0.
  - FSM: IDLE.
  - `green_q`: 0.
  - `grn_cnt`: 0.
  - `red_cnt`: `CLEAR_CYCLES` (no false clearance error after reset).
- Latency: a violation present in the `green` sample at edge k drives the corresponding flag high immediately after edge k. The same holds for `handover_cnt` increments.
- Reset asserted mid-operation returns all state to reset values asynchronously.
- A group green at the first edge after reset counts as a rise and is not a clearance error.

## Configuration
- `INTERSECTION_MONITOR_CLEAR_CHECK_EN`:
  - Defined: the `red_cnt` counters and the clearance check are built.
  - Undefined: no `red_cnt` logic exists, `clear_err` is tied to 0, and clearance never contributes to `first_err_group`.
- All other checks are identical in both builds.

## Test plan
All scenarios use the defaults.
- Conflict: `green=4'b0011` for one cycle → `conflict_err=1` after that edge, `first_err_group=0`, and both stay set until `err_clr`.
- Compatible pair: `green=4'b0110` for 10 cycles → all flags stay 0.
- Minimum green: group 1 green for 2 cycles then red → `min_green_err=1`, `first_err_group=1`. Repeat with 3 cycles green → no error.
- Clearance (macro defined): group 2 falls, then group 3 rises 1 cycle later → `clear_err=1`, `first_err_group=2`. Group 3 rising 2 cycles later → no error. With the macro undefined, `clear_err` stays 0 in both cases.
- Handover: `sel_first=0`, `sel_second=1`, pattern `0001 → 0000 → 0000 → 0010` repeated 300 times → `handover_cnt` saturates at 255. Changing `sel_second` mid-sequence → no increment for that sequence.
- Clear race: `err_clr=1` in the same cycle as a new conflict → `conflict_err` remains 1, with `first_err_group` recaptured.

Source files
------------

// File: rtl/intersection_monitor_if.sv
// Signal bundle between the intersection controller side and the safety monitor.
// The controller side drives greens and controls; the monitor returns flags and count.
`timescale 1ns/1ps
interface intersection_monitor_if #(
    parameter int NUM_GROUPS = 4,
    parameter int CNT_W      = 8
);
    localparam int SW = $clog2(NUM_GROUPS);

    logic [NUM_GROUPS-1:0] green;
    logic                  err_clr;
    logic [SW-1:0]         sel_first;
    logic [SW-1:0]         sel_second;
    logic                  conflict_err;
    logic                  min_green_err;
    logic                  clear_err;
    logic [SW-1:0]         first_err_group;
    logic [CNT_W-1:0]      handover_cnt;

    modport master (
        output green, err_clr, sel_first, sel_second,
        input  conflict_err, min_green_err, clear_err,
        input  first_err_group, handover_cnt
    );

    modport slave (
        input  green, err_clr, sel_first, sel_second,
        output conflict_err, min_green_err, clear_err,
        output first_err_group, handover_cnt
    );
endinterface

// File: rtl/intersection_monitor.sv
// Runtime safety monitor: conflicting greens, minimum green, all-red clearance, handover count.
// Clearance counters and check exist only when INTERSECTION_MONITOR_CLEAR_CHECK_EN is defined.
`timescale 1ns/1ps
module intersection_monitor #(
    parameter int                             NUM_GROUPS    = 4,
    parameter logic [NUM_GROUPS*NUM_GROUPS-1:0] CONFLICT_MASK = 16'h080E,
    parameter int                             MIN_GREEN     = 3,
    parameter int                             CLEAR_CYCLES  = 2,
    parameter int                             CNT_W         = 8
) (
    input logic                   clock,
    input logic                   reset,
    intersection_monitor_if.slave mon
);
    localparam int SW = $clog2(NUM_GROUPS);
    localparam int GW = $clog2(MIN_GREEN + 1);
    localparam int NN = NUM_GROUPS * NUM_GROUPS;

    typedef enum logic {IDLE, ARMED} hand_state_t;

    function automatic logic conflicts(input int i, input int j);
        logic [NN-1:0] a;
        logic [NN-1:0] b;
        a = CONFLICT_MASK >> (i * NUM_GROUPS + j);
        b = CONFLICT_MASK >> (j * NUM_GROUPS + i);
        return a[0] | b[0];
    endfunction

    logic [NUM_GROUPS-1:0]         green_q;
    logic [NUM_GROUPS-1:0]         rise;
    logic [NUM_GROUPS-1:0]         fall;
    logic [NUM_GROUPS-1:0][GW-1:0] grn_cnt;
    logic [NUM_GROUPS-1:0]         off;
    logic                          conf_hit;
    logic                          mg_hit;
    logic                          clr_hit;
    logic [SW-1:0]                 low_grp;
    logic                          conf_flag;
    logic                          mg_flag;
    logic                          clr_flag;
    logic [SW-1:0]                 err_grp;
    hand_state_t                   state;
    hand_state_t                   state_next;
    logic [SW-1:0]                 sel_first_q;
    logic [SW-1:0]                 sel_second_q;
    logic                          cnt_inc;
    logic [CNT_W-1:0]              cnt;

`ifdef INTERSECTION_MONITOR_CLEAR_CHECK_EN
    localparam int RW = $clog2(CLEAR_CYCLES + 1);
    logic [NUM_GROUPS-1:0][RW-1:0] red_cnt;

    // Red-time per group: held at 0 while green, the fall cycle counts as red cycle 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_GROUPS; i++) red_cnt[i] <= RW'(CLEAR_CYCLES);
        end else begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                if (mon.green[i])
                    red_cnt[i] <= '0;
                else if (red_cnt[i] != RW'(CLEAR_CYCLES))
                    red_cnt[i] <= red_cnt[i] + 1'b1;
            end
        end
    end
`endif

    // Edge detection and per-check violation detection, lowest offender selected.
    always_comb begin
        rise     = mon.green & ~green_q;
        fall     = ~mon.green & green_q;
        conf_hit = 1'b0;
        mg_hit   = 1'b0;
        clr_hit  = 1'b0;
        off      = '0;
        low_grp  = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            for (int j = i + 1; j < NUM_GROUPS; j++) begin
                if (conflicts(i, j) && mon.green[i] && mon.green[j]) begin
                    conf_hit = 1'b1;
                    off[i]   = 1'b1;
                end
            end
            if (fall[i] && grn_cnt[i] < GW'(MIN_GREEN)) begin
                mg_hit = 1'b1;
                off[i] = 1'b1;
            end
        end
`ifdef INTERSECTION_MONITOR_CLEAR_CHECK_EN
        for (int j = 0; j < NUM_GROUPS; j++) begin
            for (int i = 0; i < NUM_GROUPS; i++) begin
                if (i != j && conflicts(i, j) && rise[j] &&
                    red_cnt[i] < RW'(CLEAR_CYCLES)) begin
                    clr_hit = 1'b1;
                    off[(i < j) ? i : j] = 1'b1;
                end
            end
        end
`endif
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (off[i]) low_grp = SW'(i);
        end
    end

    // Previous green sample and saturating green-time counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            green_q <= '0;
            grn_cnt <= '0;
        end else begin
            green_q <= mon.green;
            for (int i = 0; i < NUM_GROUPS; i++) begin
                if (!mon.green[i])
                    grn_cnt[i] <= '0;
                else if (grn_cnt[i] != GW'(MIN_GREEN))
                    grn_cnt[i] <= grn_cnt[i] + 1'b1;
            end
        end
    end

    // Sticky flags; a new error in the clear cycle wins and is recaptured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conf_flag <= 1'b0;
            mg_flag   <= 1'b0;
            clr_flag  <= 1'b0;
            err_grp   <= '0;
        end else begin
            if (mon.err_clr) begin
                conf_flag <= conf_hit;
                mg_flag   <= mg_hit;
                clr_flag  <= clr_hit;
            end else begin
                conf_flag <= conf_flag | conf_hit;
                mg_flag   <= mg_flag | mg_hit;
                clr_flag  <= clr_flag | clr_hit;
            end
            if ((conf_hit || mg_hit || clr_hit) &&
                (mon.err_clr || !(conf_flag || mg_flag || clr_flag)))
                err_grp <= low_grp;
            else if (mon.err_clr)
                err_grp <= '0;
        end
    end

    // Handover next-state: arm on first-only green, count on second-only green.
    always_comb begin
        state_next = state;
        cnt_inc    = 1'b0;
        if (mon.sel_first != sel_first_q || mon.sel_second != sel_second_q ||
            mon.sel_first == mon.sel_second) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mon.green[mon.sel_first] && !mon.green[mon.sel_second])
                        state_next = ARMED;
                end
                ARMED: begin
                    if (!mon.green[mon.sel_first] && mon.green[mon.sel_second]) begin
                        state_next = IDLE;
                        cnt_inc    = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Handover state, selector history and saturating counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sel_first_q  <= '0;
            sel_second_q <= '0;
            cnt          <= '0;
        end else begin
            state        <= state_next;
            sel_first_q  <= mon.sel_first;
            sel_second_q <= mon.sel_second;
            if (cnt_inc && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    assign mon.conflict_err    = conf_flag;
    assign mon.min_green_err   = mg_flag;
    assign mon.clear_err       = clr_flag;
    assign mon.first_err_group = err_grp;
    assign mon.handover_cnt    = cnt;
endmodule

// File: tb/tb_intersection_monitor.sv
// Scoreboard testbench for intersection_monitor with default parameters.
// Clearance expectations follow INTERSECTION_MONITOR_CLEAR_CHECK_EN.
`timescale 1ns/1ps
module tb_intersection_monitor;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    intersection_monitor_if #(.NUM_GROUPS(4), .CNT_W(8)) bus ();

    intersection_monitor dut (
        .clock (clock),
        .reset (reset),
        .mon   (bus)
    );

`ifdef INTERSECTION_MONITOR_CLEAR_CHECK_EN
    localparam logic CE = 1'b1;
`else
    localparam logic CE = 1'b0;
`endif

    typedef struct packed {
        logic       c;
        logic       m;
        logic       k;
        logic [1:0] g;
        logic [7:0] n;
    } obs_t;

    typedef struct packed {
        logic [3:0] green;
        logic       clr;
        obs_t       e;
    } step_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t observe();
        return {bus.conflict_err, bus.min_green_err, bus.clear_err,
                bus.first_err_group, bus.handover_cnt};
    endfunction

    task automatic do_reset();
        bus.green      = 4'b0000;
        bus.err_clr    = 1'b0;
        bus.sel_first  = 2'd0;
        bus.sel_second = 2'd0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        reset          = 1'b1;
        bus.green      = 4'b0000;
        bus.err_clr    = 1'b0;
        bus.sel_first  = 2'd0;
        bus.sel_second = 2'd0;
        #2;
        got = observe();
        checks++;
        if (got !== 13'd0) begin
            errors++;
            $display("FAIL reset got=%b want=%b", got, 13'd0);
        end
    endtask

    task automatic test_conflict();
        step_t tbl [8];
        obs_t  got;
        obs_t  exp;
        do_reset();
        tbl = '{
            '{4'b0011, 1'b0, '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b1, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b1100, 1'b0, '{1'b1, 1'b0, 1'b0, 2'd2, 8'd0}},
            '{4'b1100, 1'b0, '{1'b1, 1'b0, 1'b0, 2'd2, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd2, 8'd0}}
        };
        foreach (tbl[i]) begin
            bus.green   = tbl[i].green;
            bus.err_clr = tbl[i].clr;
            sb.push_back(tbl[i].e);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL conflict[%0d] got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_compatible();
        obs_t got;
        obs_t exp;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.green = (i < 10) ? 4'b0110 : 4'b0000;
            sb.push_back(13'd0);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL compatible[%0d] got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_min_green();
        step_t tbl [8];
        obs_t  got;
        obs_t  exp;
        do_reset();
        tbl = '{
            '{4'b0010, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0010, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b0, 1'b1, 1'b0, 2'd1, 8'd0}},
            '{4'b0000, 1'b1, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0010, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0010, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0010, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}}
        };
        foreach (tbl[i]) begin
            bus.green   = tbl[i].green;
            bus.err_clr = tbl[i].clr;
            sb.push_back(tbl[i].e);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL min_green[%0d] got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_clearance();
        step_t tbl [10];
        obs_t  got;
        obs_t  exp;
        do_reset();
        tbl = '{
            '{4'b0100, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0100, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0100, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b1000, 1'b0, '{1'b0, 1'b0, CE, (CE ? 2'd2 : 2'd0), 8'd0}},
            '{4'b1000, 1'b1, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b1000, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0100, 1'b0, '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0}}
        };
        foreach (tbl[i]) begin
            bus.green   = tbl[i].green;
            bus.err_clr = tbl[i].clr;
            sb.push_back(tbl[i].e);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clearance[%0d] got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_clear_race();
        step_t tbl [6];
        obs_t  got;
        obs_t  exp;
        do_reset();
        tbl = '{
            '{4'b0011, 1'b0, '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd0, 8'd0}},
            '{4'b1100, 1'b1, '{1'b1, 1'b0, 1'b0, 2'd2, 8'd0}},
            '{4'b0000, 1'b0, '{1'b1, 1'b1, 1'b0, 2'd2, 8'd0}}
        };
        foreach (tbl[i]) begin
            bus.green   = tbl[i].green;
            bus.err_clr = tbl[i].clr;
            sb.push_back(tbl[i].e);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clear_race[%0d] got=%b want=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_handover();
        logic [3:0] pat [4];
        logic [1:0] sec [4];
        obs_t       got;
        obs_t       exp;
        int         cnt_ref;
        pat = '{4'b0001, 4'b0000, 4'b0000, 4'b0010};
        sec = '{2'd1, 2'd2, 2'd1, 2'd1};
        do_reset();
        bus.sel_first  = 2'd0;
        bus.sel_second = 2'd1;
        cnt_ref = 0;
        for (int s = -1; s < 1204; s++) begin
            if (s < 0) begin
                bus.green = 4'b0000;
            end else if (s < 4) begin
                bus.green      = pat[s];
                bus.sel_second = sec[s];
            end else begin
                bus.green      = pat[s % 4];
                bus.sel_second = 2'd1;
                if (s % 4 == 3 && cnt_ref < 255) cnt_ref++;
            end
            exp   = 13'd0;
            exp.n = 8'(cnt_ref);
            sb.push_back(exp);
            @(posedge clock);
            #1;
            exp = sb.pop_front();
            got = observe();
            checks++;
            if (got.n !== exp.n) begin
                errors++;
                $display("FAIL handover[%0d] got=%0d want=%0d", s, got.n, exp.n);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        #2;
        reset = 1'b1;
        #1;
        got = observe();
        checks++;
        if (got !== 13'd0) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", got, 13'd0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_compatible();
        test_min_green();
        test_clearance();
        test_clear_race();
        test_handover();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
